adder_rr_arbiter: RTL and testbench

//  Shares one single-precision FP adder (a/b/z strobe-ack handshake) between NUM_REQ requesters.

---
 rtl/adder_arb_pkg.sv | 34 +++
 rtl/rr_picker.sv | 40 ++++
 rtl/adder_rr_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_adder_rr_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared constants, state encoding and helpers for adder_rr_arbiter
//
// Purpose: FP word geometry, FSM state encoding and the operand sign helper
//          used by the adder round-robin arbiter.
// Ports:   none (package)
package adder_arb_pkg;

  localparam int FP_W        = 32;
  localparam int FP_SIGN_BIT = 31;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEND_A = 3'd1;
  localparam logic [2:0] ST_SEND_B = 3'd2;
  localparam logic [2:0] ST_WAIT_Z = 3'd3;
  localparam logic [2:0] ST_RETURN = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SEND_A = ST_SEND_A,
    S_SEND_B = ST_SEND_B,
    S_WAIT_Z = ST_WAIT_Z,
    S_RETURN = ST_RETURN
  } arb_state_t;

  // Flipping only the sign bit turns a+b into a-b. This is applied blindly,
  // so NaN operands get their sign flipped too.
  function automatic logic [FP_W-1:0] apply_sub(input logic [FP_W-1:0] b, input logic sub);
    logic [FP_W-1:0] r;
    r = b;
    r[FP_SIGN_BIT] = b[FP_SIGN_BIT] ^ sub;
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick of the next requester
//
// Purpose: scans req starting one past last_grant, wrapping modulo NUM_REQ,
//          and reports the first set bit.
// Ports:
//   req         in   NUM_REQ  pending request vector
//   last_grant  in   IDX_W    index granted most recently
//   found       out  1        at least one request pending
//   idx         out  IDX_W    chosen requester (0 when found is low)
module rr_picker
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Offset k=NUM_REQ wraps back to last_grant itself, so a lone requester
    // is still picked again after its own grant.
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = int'(last_grant) + k;
      if (c >= NUM_REQ) begin
        c = c - NUM_REQ;
      end
      if (!found && req[IDX_W'(c)]) begin
        found = 1'b1;
        idx   = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// rtl/adder_rr_arbiter.sv - round-robin share of one strobe/ack FP adder between NUM_REQ requesters
//
// Purpose: grants one requester at a time, feeds its operands to the shared
//          adder over the a/b/z strobe-ack handshake, and returns the sum only
//          to the granted requester.
// Build option: ADDER_ARB_SUB_EN adds port req_sub; a set bit at grant
//          inverts the sign of operand b so the adder computes a-b.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_a/req_b     per-requester request and operands (32-bit slices)
//   req_sub                   per-requester subtract select (ADDER_ARB_SUB_EN only)
//   req_ready                 one-hot single-cycle accept pulse
//   resp_valid/resp_z         one-hot result valid for the granted requester, result
//   resp_ready                per-requester result consume
//   busy, grant_idx           operation in flight, current/last granted index
//   add_a/add_a_stb/add_a_ack operand a handshake to the adder
//   add_b/add_b_stb/add_b_ack operand b handshake to the adder
//   add_z/add_z_stb/add_z_ack result handshake from the adder
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
`ifdef ADDER_ARB_SUB_EN
  input  logic [NUM_REQ-1:0]      req_sub,
`endif
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [FP_W-1:0]         resp_z,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_idx,
  output logic [FP_W-1:0]         add_a,
  output logic [FP_W-1:0]         add_b,
  output logic                    add_a_stb,
  input  logic                    add_a_ack,
  output logic                    add_b_stb,
  input  logic                    add_b_ack,
  input  logic [FP_W-1:0]         add_z,
  input  logic                    add_z_stb,
  output logic                    add_z_ack
);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [FP_W-1:0]  op_a;
  logic [FP_W-1:0]  op_b;
  logic [IDX_W-1:0] last_grant;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [FP_W-1:0]  sel_a;
  logic [FP_W-1:0]  sel_b;
  logic             sel_sub;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  // Operand mux for the candidate requester; constant slice bounds keep
  // the select simple for any NUM_REQ.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) begin
        sel_a = req_a[FP_W*k +: FP_W];
        sel_b = req_b[FP_W*k +: FP_W];
      end
    end
  end

`ifdef ADDER_ARB_SUB_EN
  assign sel_sub = req_sub[pick_idx];
`else
  assign sel_sub = 1'b0;
`endif

  // Next state and output decode. Every handshake output depends only on
  // the registered state and latched operands, never on an input.
  always_comb begin
    state_nxt  = state;
    add_a_stb  = 1'b0;
    add_b_stb  = 1'b0;
    add_z_ack  = 1'b0;
    add_a      = '0;
    add_b      = '0;
    resp_valid = '0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          state_nxt = S_SEND_A;
        end
      end
      S_SEND_A: begin
        add_a_stb = 1'b1;
        add_a     = op_a;
        if (add_a_ack) begin
          state_nxt = S_SEND_B;
        end
      end
      S_SEND_B: begin
        add_b_stb = 1'b1;
        add_b     = op_b;
        if (add_b_ack) begin
          state_nxt = S_WAIT_Z;
        end
      end
      S_WAIT_Z: begin
        add_z_ack = 1'b1;
        if (add_z_stb) begin
          state_nxt = S_RETURN;
        end
      end
      S_RETURN: begin
        for (int k = 0; k < NUM_REQ; k++) begin
          resp_valid[k] = (grant_idx == IDX_W'(k));
        end
        // Only the granted requester can release the result.
        if (resp_ready[grant_idx]) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant bookkeeping. last_grant resets to NUM_REQ-1 so the first scan
  // starts at requester 0. It only advances once the result is consumed,
  // which keeps the rotation tied to completed operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      grant_idx  <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      req_ready  <= '0;
      resp_z     <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            op_a      <= sel_a;
            op_b      <= apply_sub(sel_b, sel_sub);
            grant_idx <= pick_idx;
            req_ready <= NUM_REQ'(1) << pick_idx;
          end
        end
        S_WAIT_Z: begin
          if (add_z_stb) begin
            resp_z <= add_z;
          end
        end
        S_RETURN: begin
          if (resp_ready[grant_idx]) begin
            last_grant <= grant_idx;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb/tb_adder_rr_arbiter.sv - scoreboard bench for adder_rr_arbiter with a behavioural strobe/ack adder
module tb_adder_rr_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
`ifdef ADDER_ARB_SUB_EN
  logic [N-1:0]    req_sub;
`endif
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_z;
  logic [N-1:0]    resp_ready;
  logic            busy;
  logic [IW-1:0]   grant_idx;
  logic [31:0]     add_a, add_b, add_z;
  logic            add_a_stb, add_a_ack, add_b_stb, add_b_ack, add_z_stb, add_z_ack;

  always #5 clk = ~clk;

  adder_rr_arbiter #(.NUM_REQ(N), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
`ifdef ADDER_ARB_SUB_EN
    .req_sub    (req_sub),
`endif
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_z     (resp_z),
    .resp_ready (resp_ready),
    .busy       (busy),
    .grant_idx  (grant_idx),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_a_stb  (add_a_stb),
    .add_a_ack  (add_a_ack),
    .add_b_stb  (add_b_stb),
    .add_b_ack  (add_b_ack),
    .add_z      (add_z),
    .add_z_stb  (add_z_stb),
    .add_z_ack  (add_z_ack)
  );

  // Behavioural single-precision adder (normal numbers and zero only).
  function automatic logic [63:0] sp2dp(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return {x[31], 63'd0};
    e = {3'b000, x[30:23]} + 11'd896;
    return {x[31], e, x[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] dp2sp(input logic [63:0] d);
    logic [10:0] e;
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] sp_add(input logic [31:0] x, input logic [31:0] y);
    real rx, ry;
    rx = $bitstoreal(sp2dp(x));
    ry = $bitstoreal(sp2dp(y));
    return dp2sp($realtobits(rx + ry));
  endfunction

  logic [1:0]  ad_st;
  logic [31:0] ad_a, ad_b;
  int          ad_dly;

  always @(posedge clk) begin
    if (rst) begin
      ad_st <= 2'd0; add_a_ack <= 1'b0; add_b_ack <= 1'b0;
      add_z_stb <= 1'b0; add_z <= 32'd0; ad_dly <= 0;
      ad_a <= 32'd0; ad_b <= 32'd0;
    end else begin
      case (ad_st)
        2'd0: begin
          add_a_ack <= 1'b1;
          if (add_a_stb && add_a_ack) begin ad_a <= add_a; add_a_ack <= 1'b0; ad_st <= 2'd1; end
        end
        2'd1: begin
          add_b_ack <= 1'b1;
          if (add_b_stb && add_b_ack) begin ad_b <= add_b; add_b_ack <= 1'b0; ad_st <= 2'd2; ad_dly <= 3; end
        end
        2'd2: begin
          if (ad_dly == 0) begin add_z <= sp_add(ad_a, ad_b); add_z_stb <= 1'b1; ad_st <= 2'd3; end
          else ad_dly <= ad_dly - 1;
        end
        default: begin
          if (add_z_stb && add_z_ack) begin add_z_stb <= 1'b0; ad_st <= 2'd0; end
        end
      endcase
    end
  end

  // Scoreboard.
  typedef struct { int idx; logic [31:0] z; } exp_t;
  exp_t sb[$];
  int n_vec  = 0;
  int n_miss = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void expect_resp(input int idx, input logic [31:0] z);
    exp_t e;
    e.idx = idx;
    e.z   = z;
    sb.push_back(e);
  endfunction

  // Monitor: checks every completed response handshake against the queue.
  always @(negedge clk) begin : monitor
    int   got_idx;
    exp_t e;
    if (!rst && ((resp_valid & resp_ready) != '0)) begin
      got_idx = -1;
      for (int i = 0; i < N; i++) if (resp_valid[i]) got_idx = i;
      chk("resp_onehot", 32'($countones(resp_valid)), 32'd1);
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_resp: got idx %0d z %h expected none", got_idx, resp_z);
      end else begin
        e = sb.pop_front();
        chk("resp_idx", 32'(got_idx), 32'(e.idx));
        chk("resp_z", resp_z, e.z);
      end
    end
  end

  // Requester driver state.
  int           reissue[N];
  logic [31:0]  nxt_a[N];
  logic [31:0]  nxt_b[N];
  int           rr_seen[N];
  logic [N-1:0] rr_prev;

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
    set_ops(i, a, b);
    req_valid[i] = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        chk("req_ready_pulse", 32'(rr_prev[i]), 32'd0);
        rr_seen[i]++;
        if (reissue[i] > 0) begin
          reissue[i]--;
          set_ops(i, nxt_a[i], nxt_b[i]);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    rr_prev = req_ready;
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < budget) begin
      step();
      t++;
    end
    chk("drain_done", 32'(sb.size() == 0 && !busy), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) reissue[i] = 0;
    sb.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_z"}, resp_z, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_grant_idx"}, 32'(grant_idx), 32'd0);
    chk({tag, "_stb_ack"}, 32'({add_a_stb, add_b_stb, add_z_ack}), 32'd0);
    chk({tag, "_add_ab"}, add_a | add_b, 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    int base;
    logic [31:0] snap;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = '1; rr_prev = '0;
`ifdef ADDER_ARB_SUB_EN
    req_sub = '0;
`endif
    for (int i = 0; i < N; i++) begin reissue[i] = 0; rr_seen[i] = 0; nxt_a[i] = 0; nxt_b[i] = 0; end
    repeat (3) step();
    chk_idle_outputs("reset");
    rst = 1'b0;
    step();

    // 1: single request, 1.0 + 2.0 = 3.0
    expect_resp(0, 32'h40400000);
    issue(0, 32'h3F800000, 32'h40000000);
    drain(200);
    chk("single_req_ready_count", 32'(rr_seen[0]), 32'd1);

    // 2: contention after reset, grant order 0,1,2,3,0
    do_reset();
    expect_resp(0, 32'h40400000);
    expect_resp(1, 32'h40800000);
    expect_resp(2, 32'h40E00000);
    expect_resp(3, 32'h3F800000);
    expect_resp(0, 32'h40C00000);
    reissue[0] = 1; nxt_a[0] = 32'h40A00000; nxt_b[0] = 32'h3F800000;
    issue(0, 32'h3F800000, 32'h40000000);
    issue(1, 32'h40000000, 32'h40000000);
    issue(2, 32'h40400000, 32'h40800000);
    issue(3, 32'h3F000000, 32'h3F000000);
    drain(500);

    // 3: fairness, req1 keeps requesting, req3 arrives during req1's op
    expect_resp(1, 32'h40800000);
    expect_resp(3, 32'h3F800000);
    expect_resp(1, 32'h40800000);
    expect_resp(1, 32'h40800000);
    reissue[1] = 2; nxt_a[1] = 32'h40000000; nxt_b[1] = 32'h40000000;
    base = rr_seen[1];
    issue(1, 32'h40000000, 32'h40000000);
    t = 0;
    while (rr_seen[1] == base && t < 50) begin step(); t++; end
    chk("fair_first_grant", 32'(rr_seen[1] - base), 32'd1);
    issue(3, 32'h3F000000, 32'h3F000000);
    drain(500);

    // 4: backpressure on requester 2 with requester 0 waiting
    expect_resp(2, 32'h40E00000);
    expect_resp(0, 32'h40000000);
    resp_ready[2] = 1'b0;
    issue(2, 32'h40400000, 32'h40800000);
    issue(0, 32'h3F800000, 32'h3F800000);
    t = 0;
    while (!resp_valid[2] && t < 100) begin step(); t++; end
    chk("bp_resp_valid_seen", 32'(resp_valid[2]), 32'd1);
    snap = resp_z;
    chk("bp_resp_z", snap, 32'h40E00000);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("bp_resp_valid_hold", 32'(resp_valid), 32'b0100);
      chk("bp_resp_z_stable", resp_z, snap);
      chk("bp_no_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready[2] = 1'b1;
    drain(300);

    // 5: reset while waiting on the adder result
    issue(1, 32'h40000000, 32'h40000000);
    t = 0;
    while (!add_z_ack && t < 100) begin step(); t++; end
    chk("rst_reached_wait_z", 32'(add_z_ack), 32'd1);
    rst = 1'b1;
    req_valid = '0;
    step();
    chk_idle_outputs("midop_reset");
    rst = 1'b0;
    expect_resp(0, 32'h40400000);
    expect_resp(2, 32'h40E00000);
    issue(2, 32'h40400000, 32'h40800000);
    issue(0, 32'h3F800000, 32'h40000000);
    drain(300);

    // 6: optional subtract, 5.0 and 2.0 on requester 1
`ifdef ADDER_ARB_SUB_EN
    req_sub[1] = 1'b1;
    expect_resp(1, 32'h40400000);
`else
    expect_resp(1, 32'h40E00000);
`endif
    issue(1, 32'h40A00000, 32'h40000000);
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
